// File: rtl/lfa_pkg.sv
// Shared types for the LFA line tracker: FSM states, sensor patterns, motor codes
// and the H-bridge direction-pin encodings.
package lfa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLLOW,
        ST_NODE,
        ST_STOP,
        ST_LOST
    } state_t;

    typedef enum logic [2:0] {
        PAT_ALL_B,
        PAT_RDRIFT,
        PAT_LDRIFT,
        PAT_CENTER,
        PAT_NONE,
        PAT_HOLD
    } pattern_t;

    typedef enum logic [2:0] {
        MC_OFF,
        MC_FWD,
        MC_PIVR,
        MC_PIVL,
        MC_NODEFWD
    } mcode_t;

    // {a, b} pin pair for one motor
    localparam logic [1:0] DIR_OFF = 2'b00;
    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

endpackage

// File: rtl/lfa_sample_classifier.sv
// Combinational black/white classification of one left/middle/right sample set
// into a single prioritised line pattern.
module lfa_sample_classifier
    import lfa_pkg::*;
#(
    parameter int ADC_W  = 12,
    parameter int HI_THR = 1000,
    parameter int LO_THR = 200
) (
    input  logic [ADC_W-1:0] left,
    input  logic [ADC_W-1:0] middle,
    input  logic [ADC_W-1:0] right,
    output pattern_t         pattern
);

    localparam logic [ADC_W-1:0] HI_T = ADC_W'(HI_THR);
    localparam logic [ADC_W-1:0] LO_T = ADC_W'(LO_THR);

    logic b_l, b_m, b_r;
    logic w_l, w_m, w_r;

    assign b_l = (left   > HI_T);
    assign b_m = (middle > HI_T);
    assign b_r = (right  > HI_T);
    assign w_l = (left   < LO_T);
    assign w_m = (middle < LO_T);
    assign w_r = (right  < LO_T);

    always_comb begin
        pattern = PAT_HOLD;
        if (b_l && b_m && b_r) begin
            pattern = PAT_ALL_B;
        end else if (b_r && w_l) begin
            pattern = PAT_RDRIFT;
        end else if (b_l && w_r) begin
            pattern = PAT_LDRIFT;
        end else if (w_l && b_m && w_r) begin
            pattern = PAT_CENTER;
        end else if (w_l && w_m && w_r) begin
            pattern = PAT_NONE;
        end
    end

endmodule

// File: rtl/lfa_line_tracker.sv
// Three-sensor line follower: steers the H-bridge from classified samples,
// counts debounced nodes, stops at a chosen node and detects a lost line.
module lfa_line_tracker
    import lfa_pkg::*;
#(
    parameter int ADC_W         = 12,
    parameter int HI_THR        = 1000,
    parameter int LO_THR        = 200,
    parameter int DUTY_W        = 4,
    parameter int FWD_DUTY      = 5,
    parameter int TURN_HI       = 7,
    parameter int TURN_LO       = 3,
    parameter int NODE_DUTY     = 5,
    parameter int NODE_DEBOUNCE = 16,
    parameter int LOST_SAMPLES  = 64,
    parameter int NODE_W        = 8,
    parameter int STOP_NODE     = 5
) (
    input  logic              clk_3125KHz,
    input  logic              reset,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [ADC_W-1:0]  left,
    input  logic [ADC_W-1:0]  middle,
    input  logic [ADC_W-1:0]  right,
    output logic              m1_a,
    output logic              m1_b,
    output logic              m2_a,
    output logic              m2_b,
    output logic [DUTY_W-1:0] dc1,
    output logic [DUTY_W-1:0] dc2,
    output logic              node_flag,
    output logic              node_pulse,
    output logic [NODE_W-1:0] node,
    output logic              lost,
    output logic              stopped,
    output logic [7:0]        fpga_LED
);

    localparam int DEB_W  = $clog2(NODE_DEBOUNCE + 1);
    localparam int LOST_W = $clog2(LOST_SAMPLES + 1);
    localparam int OUT_W  = 4 + 2 * DUTY_W;

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(NODE_DEBOUNCE);
    localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_SAMPLES);
    localparam logic [DUTY_W-1:0] FWD_DC   = DUTY_W'(FWD_DUTY);
    localparam logic [DUTY_W-1:0] THI_DC   = DUTY_W'(TURN_HI);
    localparam logic [DUTY_W-1:0] TLO_DC   = DUTY_W'(TURN_LO);
    localparam logic [DUTY_W-1:0] NODE_DC  = DUTY_W'(NODE_DUTY);

    // Pin/duty image of a motor code: {m1_a, m1_b, m2_a, m2_b, dc1, dc2}
    function automatic logic [OUT_W-1:0] decode(input mcode_t mc);
        case (mc)
            MC_FWD:     decode = {DIR_FWD, DIR_FWD, FWD_DC, FWD_DC};
            MC_PIVR:    decode = {DIR_FWD, DIR_REV, THI_DC, TLO_DC};
            MC_PIVL:    decode = {DIR_REV, DIR_FWD, TLO_DC, THI_DC};
            MC_NODEFWD: decode = {DIR_FWD, DIR_FWD, NODE_DC, NODE_DC};
            default:    decode = {DIR_OFF, DIR_OFF, {(2 * DUTY_W){1'b0}}};
        endcase
    endfunction

    pattern_t pattern;

    lfa_sample_classifier #(
        .ADC_W  (ADC_W),
        .HI_THR (HI_THR),
        .LO_THR (LO_THR)
    ) u_classifier (
        .left    (left),
        .middle  (middle),
        .right   (right),
        .pattern (pattern)
    );

    state_t            state_q,    state_d;
    mcode_t            mcode_q,    mcode_d;
    logic [DEB_W-1:0]  deb_q,      deb_d,      deb_inc;
    logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d, lost_inc;
    logic [NODE_W-1:0] node_q,     node_d,     node_inc;
    logic [OUT_W-1:0]  out_q,      out_d;
    logic              pulse_q,    pulse_d;
    logic              flag_q,     flag_d;
    logic              lost_q,     lost_d;
    logic              stopped_q,  stopped_d;

    assign deb_inc  = (deb_q < DEB_MAX) ? deb_q + DEB_W'(1) : deb_q;
    assign lost_inc = (lost_cnt_q < LOST_MAX) ? lost_cnt_q + LOST_W'(1) : lost_cnt_q;
    assign node_inc = node_q + NODE_W'(1);

    always_comb begin
        state_d    = state_q;
        mcode_d    = mcode_q;
        deb_d      = deb_q;
        lost_cnt_d = lost_cnt_q;
        node_d     = node_q;
        pulse_d    = 1'b0;

        if (!en) begin
            state_d    = ST_IDLE;
            mcode_d    = MC_OFF;
            deb_d      = '0;
            lost_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FOLLOW;
                    mcode_d = MC_OFF;
                end
                ST_FOLLOW, ST_NODE: begin
                    if (sample_valid) begin
                        if (pattern == PAT_ALL_B) begin
                            lost_cnt_d = '0;
                            // While already on a node, further all-black samples just keep crossing it
                            if (state_q == ST_FOLLOW) begin
                                if (deb_inc == DEB_MAX) begin
                                    deb_d   = '0;
                                    node_d  = node_inc;
                                    pulse_d = 1'b1;
                                    if ((STOP_NODE != 0) && (node_inc == NODE_W'(STOP_NODE))) begin
                                        state_d = ST_STOP;
                                        mcode_d = MC_OFF;
                                    end else begin
                                        state_d = ST_NODE;
                                        mcode_d = MC_NODEFWD;
                                    end
                                end else begin
                                    deb_d = deb_inc;
                                end
                            end
                        end else begin
                            state_d = ST_FOLLOW;
                            deb_d   = '0;
                            case (pattern)
                                PAT_CENTER: mcode_d = MC_FWD;
                                PAT_RDRIFT: mcode_d = MC_PIVR;
                                PAT_LDRIFT: mcode_d = MC_PIVL;
                                default:    mcode_d = mcode_q;
                            endcase
                            if (pattern == PAT_NONE) begin
                                if (lost_inc == LOST_MAX) begin
                                    lost_cnt_d = '0;
                                    state_d    = ST_LOST;
                                    mcode_d    = MC_OFF;
                                end else begin
                                    lost_cnt_d = lost_inc;
                                end
                            end else begin
                                lost_cnt_d = '0;
                            end
                        end
                    end
                end
                ST_LOST: begin
                    if (sample_valid && (pattern == PAT_CENTER)) begin
                        state_d = ST_FOLLOW;
                        mcode_d = MC_FWD;
                    end
                end
                ST_STOP: begin
                    mcode_d = MC_OFF;
                end
                default: begin
                    state_d = ST_IDLE;
                    mcode_d = MC_OFF;
                end
            endcase
        end

        out_d     = decode(mcode_d);
        flag_d    = (state_d == ST_NODE);
        lost_d    = (state_d == ST_LOST);
        stopped_d = (state_d == ST_STOP);
    end

    always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mcode_q    <= MC_OFF;
            deb_q      <= '0;
            lost_cnt_q <= '0;
            node_q     <= '0;
            out_q      <= '0;
            pulse_q    <= 1'b0;
            flag_q     <= 1'b0;
            lost_q     <= 1'b0;
            stopped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcode_q    <= mcode_d;
            deb_q      <= deb_d;
            lost_cnt_q <= lost_cnt_d;
            node_q     <= node_d;
            out_q      <= out_d;
            pulse_q    <= pulse_d;
            flag_q     <= flag_d;
            lost_q     <= lost_d;
            stopped_q  <= stopped_d;
        end
    end

    assign {m1_a, m1_b, m2_a, m2_b, dc1, dc2} = out_q;
    assign node_flag  = flag_q;
    assign node_pulse = pulse_q;
    assign node       = node_q;
    assign lost       = lost_q;
    assign stopped    = stopped_q;
    assign fpga_LED   = 8'(node_q);

endmodule
